adc_tx_packer: RTL and testbench

Downstream stage of the board controller's ADC path. Captures each 12-bit conversion result presented on `dataAdc` when `readyAdc` rises, buffers it in a small FIFO, and serialises it as two tagged bytes onto an FT245-style byte write port towards the USB host. This decouples SPI-ADC conversion timing from host back-pressure and flags lost samples.

---
 rtl/adc_tx_packer.sv | 122 ++++++++++++
 tb/tb_adc_tx_packer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_tx_packer.sv
// rtl/adc_tx_packer.sv - ADC sample FIFO and tagged two-byte serialiser for an FT245-style write port
module adc_tx_packer #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic [11:0]       dataAdc,
  input  logic              readyAdc,
  input  logic              txe_n,
  output logic [7:0]        data_out,
  output logic              wr_byte,
  output logic              busy,
  output logic [ADDR_W:0]   level,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE = 2'd0, HI = 2'd1, LO = 2'd2} state_e;

  localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

  logic              rdyD;
  logic [11:0]       mem [DEPTH];
  logic [ADDR_W-1:0] wrPtr, rdPtr;
  logic [11:0]       hold;
  state_e            state, stateNext;
  logic              push, pop, full, wrAccept;
  logic              wrNext;
  logic [7:0]        dataNext;

  assign full     = (level == LEVEL_FULL);
  assign push     = readyAdc & ~rdyD & ~clr;
  assign pop      = (state == IDLE) && (level != '0) && !clr;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign wrAccept = push && (!full || pop);

  // Resetting to 1 stops a level already high at reset release from counting as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdyD <= 1'b1;
    else        rdyD <= readyAdc;
  end

  always_ff @(posedge clk) begin
    if (wrAccept) mem[wrPtr] <= dataAdc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wrPtr    <= '0;
      rdPtr    <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wrAccept) wrPtr <= wrPtr + 1'b1;
      if (pop)      rdPtr <= rdPtr + 1'b1;
      if (wrAccept && !pop)      level <= level + 1'b1;
      else if (pop && !wrAccept) level <= level - 1'b1;
      if (push && !wrAccept) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   hold <= '0;
    else if (pop) hold <= mem[rdPtr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (clr) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (level != '0) stateNext = HI;
        HI:      if (!txe_n)      stateNext = LO;
        LO:      if (!txe_n)      stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_comb begin
    wrNext   = 1'b0;
    dataNext = data_out;
    if (!clr) begin
      case (state)
        HI: if (!txe_n) begin
          wrNext   = 1'b1;
          dataNext = {4'hA, hold[11:8]};
        end
        LO: if (!txe_n) begin
          wrNext   = 1'b1;
          dataNext = hold[7:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_byte  <= 1'b0;
      data_out <= '0;
      busy     <= 1'b0;
    end else begin
      wr_byte  <= wrNext;
      data_out <= dataNext;
      busy     <= (stateNext != IDLE);
    end
  end

endmodule

// File: tb/tb_adc_tx_packer.sv
// tb/tb_adc_tx_packer.sv - directed and randomized checks of adc_tx_packer against a queue model
module tb_adc_tx_packer;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic        readyAdc = 1'b0;
  logic        txe_n = 1'b1;
  logic [11:0] dataAdc = '0;
  logic [7:0]  data_out;
  logic        wr_byte, busy, overflow;
  logic [4:0]  level;

  adc_tx_packer #(.DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .dataAdc(dataAdc), .readyAdc(readyAdc),
    .txe_n(txe_n), .data_out(data_out), .wr_byte(wr_byte), .busy(busy),
    .level(level), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: stored words as a queue, one word in flight with a byte phase.
  logic [11:0] mq[$];
  logic [7:0]  byteLog[$];
  logic [11:0] mHold = '0;
  logic [7:0]  mData = '0;
  bit mBusy = 0, mPhase = 0, mWr = 0, mOvf = 0, prevRdy = 1;
  bit pushEv, popEv;

  always begin
    @(posedge clk);
    if (!rst_n) begin
      mq.delete();
      mBusy = 0; mPhase = 0; mWr = 0; mOvf = 0; prevRdy = 1; mData = '0; mHold = '0;
    end else if (clr) begin
      mq.delete();
      mBusy = 0; mWr = 0; mOvf = 0; prevRdy = readyAdc;
    end else begin
      pushEv  = readyAdc && !prevRdy;
      prevRdy = readyAdc;
      popEv   = !mBusy && (mq.size() > 0);
      mWr     = 0;
      if (mBusy && !txe_n) begin
        mWr = 1;
        if (!mPhase) begin
          mData  = {4'hA, mHold[11:8]};
          mPhase = 1;
        end else begin
          mData = mHold[7:0];
          mBusy = 0;
        end
      end
      if (popEv) begin
        mHold  = mq.pop_front();
        mBusy  = 1;
        mPhase = 0;
      end
      if (pushEv) begin
        if (mq.size() < DEPTH) mq.push_back(dataAdc);
        else                   mOvf = 1;
      end
    end
    #1;
    if (rst_n && wr_byte) byteLog.push_back(data_out);
    check("m_wr_byte", 32'(wr_byte), 32'(mWr));
    check("m_data_out", 32'(data_out), 32'(mData));
    check("m_busy", 32'(busy), 32'(mBusy));
    check("m_level", 32'(level), mq.size());
    check("m_overflow", 32'(overflow), 32'(mOvf));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushSample(input logic [11:0] d);
    dataAdc  = d;
    readyAdc = 1'b1;
    tick(1);
    readyAdc = 1'b0;
    tick(1);
  endtask

  task automatic pulseClr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    byteLog.delete();
  endtask

  initial begin
    tick(2);
    check("rst_data_out", 32'(data_out), 0);
    check("rst_wr_byte", 32'(wr_byte), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_level", 32'(level), 0);
    check("rst_overflow", 32'(overflow), 0);
    rst_n = 1'b1;
    tick(1);

    // single sample
    txe_n = 1'b0; dataAdc = 12'h5C3; readyAdc = 1'b1;
    tick(3);
    readyAdc = 1'b0;
    tick(10);
    check("single_count", byteLog.size(), 2);
    check("single_b0", 32'(byteLog[0]), 'hA5);
    check("single_b1", 32'(byteLog[1]), 'hC3);
    check("single_ovf", 32'(overflow), 0);

    // back-pressure between the two bytes
    byteLog.delete();
    readyAdc = 1'b1;
    tick(1);
    readyAdc = 1'b0;
    tick(2);
    txe_n = 1'b1;
    tick(10);
    check("bp_stalled_count", byteLog.size(), 1);
    check("bp_busy", 32'(busy), 1);
    txe_n = 1'b0;
    tick(5);
    check("bp_count", byteLog.size(), 2);
    check("bp_b0", 32'(byteLog[0]), 'hA5);
    check("bp_b1", 32'(byteLog[1]), 'hC3);

    // overflow and pointer wrap: word 1 sits in hold, 2..17 fill the FIFO, 18 drops
    pulseClr();
    txe_n = 1'b1;
    for (int i = 1; i <= 18; i++) begin
      pushSample(12'(i));
      if (i == 17) begin
        check("ovf_level17", 32'(level), 16);
        check("ovf_flag17", 32'(overflow), 0);
      end
    end
    check("ovf_level", 32'(level), 16);
    check("ovf_flag", 32'(overflow), 1);
    txe_n = 1'b0;
    tick(70);
    check("ovf_count", byteLog.size(), 34);
    for (int i = 0; i < 17; i++) begin
      check("ovf_hi", 32'(byteLog[2*i]), 'hA0);
      check("ovf_lo", 32'(byteLog[2*i+1]), i + 1);
    end

    // push coinciding with pop while full
    pulseClr();
    txe_n = 1'b1;
    for (int i = 0; i < 17; i++) pushSample(12'(12'h100 + i));
    check("pp_full", 32'(level), 16);
    txe_n = 1'b0;
    tick(2);
    dataAdc = 12'hABC; readyAdc = 1'b1;
    tick(1);
    check("pp_level", 32'(level), 16);
    check("pp_ovf", 32'(overflow), 0);
    readyAdc = 1'b0;
    tick(70);
    check("pp_count", byteLog.size(), 36);
    check("pp_first", 32'(byteLog[0]), 'hA1);
    check("pp_last_hi", 32'(byteLog[34]), 'hAA);
    check("pp_last_lo", 32'(byteLog[35]), 'hBC);

    // clear mid-word
    pulseClr();
    txe_n = 1'b0; dataAdc = 12'h7FF; readyAdc = 1'b1;
    tick(1);
    readyAdc = 1'b0;
    tick(2);
    check("clr_b0_count", byteLog.size(), 1);
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    check("clr_busy", 32'(busy), 0);
    check("clr_level", 32'(level), 0);
    check("clr_wr", 32'(wr_byte), 0);
    pushSample(12'h123);
    tick(8);
    check("clr_count", byteLog.size(), 3);
    check("clr_b0", 32'(byteLog[0]), 'hA7);
    check("clr_next_hi", 32'(byteLog[1]), 'hA1);
    check("clr_next_lo", 32'(byteLog[2]), 'h23);

    // reset release with readyAdc already high
    byteLog.delete();
    readyAdc = 1'b1;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(5);
    check("rh_level", 32'(level), 0);
    check("rh_none", byteLog.size(), 0);
    readyAdc = 1'b0;
    tick(1);
    dataAdc = 12'h3E9; readyAdc = 1'b1;
    tick(1);
    readyAdc = 1'b0;
    tick(8);
    check("rh_count", byteLog.size(), 2);
    check("rh_b0", 32'(byteLog[0]), 'hA3);
    check("rh_b1", 32'(byteLog[1]), 'hE9);

    // random traffic with stalls and occasional clears
    pulseClr();
    for (int c = 0; c < 3000; c++) begin
      txe_n    = ($urandom_range(0, 9) < 3);
      readyAdc = 1'($urandom_range(0, 1));
      dataAdc  = 12'($urandom);
      clr      = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    clr = 1'b0; readyAdc = 1'b0; txe_n = 1'b0;
    tick(70);
    check("rnd_drained", 32'(level), 0);
    check("rnd_idle", 32'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
